vga_scan_out: RTL and testbench

- VGA raster timing generator and pixel output stage: the driving end of the pixel-coordinate/colour interface used by screen renderers (welcome, game, end screens).
- Produces the scan position x/y that renderers consume.
- Takes back the renderer's 12-bit colour and drives RGB and HSYNC/VSYNC to the monitor pins.
- Sync and blanking are delayed so they line up with the renderer's fixed pipeline latency.

---
 rtl/vga_scan_out.sv | 145 ++++++++++++++
 tb/tb_vga_scan_out.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// VGA raster timing generator and pixel output stage. Publishes the scan
// position to renderers, then drives their colour and the sync pins with sync delayed to match.
module vga_scan_out #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        active,
  output logic        frame_start,
  input  logic [11:0] color,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [3:0] div;
  logic       tick;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       h_last;
  logic       v_last;
  sync_t      sync_raw;
  sync_t      sync_d;

  assign tick   = (div == DIV_LAST);
  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_last && v_last;
      if (tick) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    active          = 1'b0;
    x               = '0;
    y               = '0;
    sync_raw        = SYNC_IDLE;
    if (hcnt < H_VIS && vcnt < V_VIS) begin
      active = 1'b1;
      x      = hcnt;
      y      = vcnt[8:0];
    end
    sync_raw.active = active;
    sync_raw.hs     = !(hcnt >= HS_FIRST && hcnt <= HS_LAST);
    sync_raw.vs     = !(vcnt >= VS_FIRST && vcnt <= VS_LAST);
  end

  // Delay line matching the renderer latency from x/y to colour.
  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign sync_d = sync_raw;
    end else begin : g_dly
      sync_t sr [PIPE_DLY];

      // NOTE: this small register array is reset on purpose: a stale
      // active bit after reset would leak renderer colour onto the DAC.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) sr[i] <= SYNC_IDLE;
        end else begin
          sr[0] <= sync_raw;
          for (int i = 1; i < PIPE_DLY; i++) sr[i] <= sr[i-1];
        end
      end

      assign sync_d = sr[PIPE_DLY-1];
    end
  endgenerate

  // Blanked colour must be black so the DAC holds its black level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r, g, b} <= 12'h000;
      hs        <= 1'b1;
      vs        <= 1'b1;
    end else begin
      {r, g, b} <= sync_d.active ? color : 12'h000;
      hs        <= sync_d.hs;
      vs        <= sync_d.vs;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out: expected sync edges and pixel samples are
// queued with their cycle numbers; a monitor compares as the DUT produces them.
module tb_vga_scan_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [9:0]  x_a, x_b, x_c;
  logic [8:0]  y_a, y_b, y_c;
  logic        act_a, act_b, act_c;
  logic        fs_a, fs_b, fs_c;
  logic [11:0] color_a, color_b, color_c;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;

  // Default timing with a two-stage renderer producing {2'b0, x}.
  logic [11:0] ren1 = '0, ren2 = '0;
  always @(posedge clk) begin
    ren1 <= {2'b00, x_a};
    ren2 <= ren1;
  end
  assign color_a = ren2;

  vga_scan_out u_a (
    .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .active(act_a),
    .frame_start(fs_a), .color(color_a), .r(r_a), .g(g_a), .b(b_a),
    .hs(hs_a), .vs(vs_a)
  );

  // Shrunk raster (16 x 11 pixels) so whole frames fit in a short run.
  assign color_b = 12'hFFF;

  vga_scan_out #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(3)
  ) u_b (
    .clk(clk), .rst(rst_b), .x(x_b), .y(y_b), .active(act_b),
    .frame_start(fs_b), .color(color_b), .r(r_b), .g(g_b), .b(b_b),
    .hs(hs_b), .vs(vs_b)
  );

  // One clk per pixel, zero-latency combinational renderer.
  assign color_c = {2'b00, x_c};

  vga_scan_out #(.CLK_DIV(1), .PIPE_DLY(0)) u_c (
    .clk(clk), .rst(rst_c), .x(x_c), .y(y_c), .active(act_c),
    .frame_start(fs_c), .color(color_c), .r(r_c), .g(g_c), .b(b_c),
    .hs(hs_c), .vs(vs_c)
  );

  int          sel = 0;
  logic        m_rst, m_hs, m_vs, m_fs, m_act;
  logic [9:0]  m_x;
  logic [8:0]  m_y;
  logic [11:0] m_rgb;

  always_comb begin
    m_rst = rst_a; m_hs = hs_a; m_vs = vs_a; m_fs = fs_a; m_act = act_a;
    m_x = x_a; m_y = y_a; m_rgb = {r_a, g_a, b_a};
    case (sel)
      1: begin
        m_rst = rst_b; m_hs = hs_b; m_vs = vs_b; m_fs = fs_b; m_act = act_b;
        m_x = x_b; m_y = y_b; m_rgb = {r_b, g_b, b_b};
      end
      2: begin
        m_rst = rst_c; m_hs = hs_c; m_vs = vs_c; m_fs = fs_c; m_act = act_c;
        m_x = x_c; m_y = y_c; m_rgb = {r_c, g_c, b_c};
      end
      default: ;
    endcase
  end

  // cyc = k while the DUT shows the state after the k-th edge since release.
  int cyc = 0;
  always @(posedge clk) begin
    if (m_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int   sig;
    logic val;
    int   cyc;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [11:0] rgb;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        act;
  } smp_t;

  ev_t   ev_q[$];
  smp_t  smp_q[$];
  string sig_name [3] = '{"hs", "vs", "frame_start"};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (dut %0d, cycle %0d)",
                  name, act, exp, sel, cyc);
  endtask

  task automatic push_ev(input int sig, input logic val, input int c);
    ev_t e;
    e.sig = sig; e.val = val; e.cyc = c;
    ev_q.push_back(e);
  endtask

  task automatic push_smp(input int c, input logic [11:0] rgb, input logic [9:0] xv,
                          input logic [8:0] yv, input logic av);
    smp_t s;
    s.cyc = c; s.rgb = rgb; s.x = xv; s.y = yv; s.act = av;
    smp_q.push_back(s);
  endtask

  // Small raster: per line v, hs low over cycles [32v+24, 32v+30); vs low over
  // lines 7..8 = [228, 292); frame_start high for cycle 352 of each frame.
  task automatic push_b_lines(input int base, input int nl);
    for (int v = 0; v < nl; v++) begin
      push_ev(0, 1'b0, base + 32*v + 24);
      push_ev(0, 1'b1, base + 32*v + 30);
      if (v == 6) push_ev(1, 1'b0, base + 228);
      if (v == 8) push_ev(1, 1'b1, base + 292);
    end
    if (nl == 11) begin
      push_ev(2, 1'b1, base + 352);
      push_ev(2, 1'b0, base + 353);
    end
  endtask

  task automatic ev_match(input int sig, input logic val);
    ev_t e;
    if (ev_q.size() == 0) begin
      check({"unexpected ", sig_name[sig], " edge"}, 32'(val), 32'(!val));
    end else begin
      e = ev_q.pop_front();
      check({sig_name[sig], " edge signal"}, 32'(sig), 32'(e.sig));
      check({sig_name[sig], " edge value"}, 32'(val), 32'(e.val));
      check({sig_name[sig], " edge cycle"}, 32'(cyc), 32'(e.cyc));
    end
  endtask

  logic p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0;
  smp_t s_cur;

  always @(negedge clk) begin
    if (!m_rst) begin
      if (m_hs !== p_hs) ev_match(0, m_hs);
      if (m_vs !== p_vs) ev_match(1, m_vs);
      if (m_fs !== p_fs) ev_match(2, m_fs);
      while (smp_q.size() > 0 && smp_q[0].cyc == cyc) begin
        s_cur = smp_q.pop_front();
        check("pixel rgb", 32'(m_rgb), 32'(s_cur.rgb));
        check("pixel x",   32'(m_x),   32'(s_cur.x));
        check("pixel y",   32'(m_y),   32'(s_cur.y));
        check("pixel active", 32'(m_act), 32'(s_cur.act));
      end
    end
    p_hs = m_hs;
    p_vs = m_vs;
    p_fs = m_fs;
  end

  task automatic release_rst(input int s);
    @(posedge clk);
    #2;
    case (s)
      0: rst_a = 1'b0;
      1: rst_b = 1'b0;
      default: rst_c = 1'b0;
    endcase
  endtask

  task automatic run_until(input int end_cyc);
    while (cyc < end_cyc) @(negedge clk);
    check("expectations still pending", 32'(ev_q.size() + smp_q.size()), 32'd0);
    ev_q.delete();
    smp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " x"}, 32'(m_x), 32'd0);
    check({tag, " y"}, 32'(m_y), 32'd0);
    check({tag, " active"}, 32'(m_act), 32'd1);
    check({tag, " frame_start"}, 32'(m_fs), 32'd0);
    check({tag, " rgb"}, 32'(m_rgb), 32'h000);
    check({tag, " hs"}, 32'(m_hs), 32'd1);
    check({tag, " vs"}, 32'(m_vs), 32'd1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle("reset");
    end

    // Default timing, CLK_DIV 4, PIPE_DLY 2: pins follow counters by 3 clks.
    sel = 0;
    push_ev(0, 1'b0, 2627);
    push_ev(0, 1'b1, 3011);
    push_ev(0, 1'b0, 5827);
    push_ev(0, 1'b1, 6211);
    push_smp(2,    12'h000, 10'd0,   9'd0, 1'b1);
    push_smp(6,    12'h000, 10'd1,   9'd0, 1'b1);
    push_smp(7,    12'h001, 10'd1,   9'd0, 1'b1);
    push_smp(2559, 12'h27F, 10'd639, 9'd0, 1'b1);
    push_smp(2562, 12'h27F, 10'd0,   9'd0, 1'b0);
    push_smp(2563, 12'h000, 10'd0,   9'd0, 1'b0);
    push_smp(3203, 12'h000, 10'd0,   9'd1, 1'b1);
    push_smp(3222, 12'h004, 10'd5,   9'd1, 1'b1);
    push_smp(3223, 12'h005, 10'd5,   9'd1, 1'b1);
    push_smp(5759, 12'h27F, 10'd639, 9'd1, 1'b1);
    release_rst(0);
    run_until(6400);
    rst_a = 1'b1;

    // Small raster with constant white: two full frames, then reset mid-frame.
    sel = 1;
    push_b_lines(0, 11);
    push_b_lines(352, 11);
    push_b_lines(704, 4);
    push_smp(3,   12'h000, 10'd1, 9'd0, 1'b1);
    push_smp(4,   12'hFFF, 10'd2, 9'd0, 1'b1);
    push_smp(18,  12'hFFF, 10'd0, 9'd0, 1'b0);
    push_smp(19,  12'hFFF, 10'd0, 9'd0, 1'b0);
    push_smp(20,  12'h000, 10'd0, 9'd0, 1'b0);
    push_smp(164, 12'hFFF, 10'd2, 9'd5, 1'b1);
    push_smp(196, 12'h000, 10'd0, 9'd0, 1'b0);
    push_smp(354, 12'h000, 10'd1, 9'd0, 1'b1);
    push_smp(356, 12'hFFF, 10'd2, 9'd0, 1'b1);
    release_rst(1);
    run_until(842);
    check("pre-reset rgb", 32'(m_rgb), 32'hFFF);
    check("pre-reset x", 32'(m_x), 32'd5);
    check("pre-reset y", 32'(m_y), 32'd4);
    #1;
    rst_b = 1'b1;
    #1;
    check_idle("mid-frame reset");
    push_b_lines(0, 11);
    push_smp(4, 12'hFFF, 10'd2, 9'd0, 1'b1);
    release_rst(1);
    run_until(370);
    rst_b = 1'b1;

    // CLK_DIV 1, PIPE_DLY 0: 800-clk lines, colour one clk after x/y.
    sel = 2;
    push_ev(0, 1'b0, 657);
    push_ev(0, 1'b1, 753);
    push_ev(0, 1'b0, 1457);
    push_ev(0, 1'b1, 1553);
    push_smp(1,   12'h000, 10'd1, 9'd0, 1'b1);
    push_smp(2,   12'h001, 10'd2, 9'd0, 1'b1);
    push_smp(640, 12'h27F, 10'd0, 9'd0, 1'b0);
    push_smp(641, 12'h000, 10'd0, 9'd0, 1'b0);
    push_smp(804, 12'h003, 10'd4, 9'd1, 1'b1);
    release_rst(2);
    run_until(1600);
    rst_c = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
